dmem_arbiter: RTL

Arbiter sharing the single-port data memory between the pipelined CPU's MEM stage and one external device port (program/data loader or display scanner). CPU accesses win by default. A waiting device request is served in the next CPU-idle cycle, or forcibly after a bounded number of CPU-owned cycles, in which case the pipeline is stalled for one cycle. The block sits between the EX/MEM register outputs and the data memory, and supplies `cpu_stall` into the pipeline's stall network.

---
 rtl/dmem_arbiter_if.sv | 42 ++++
 rtl/dmem_arbiter.sv | 89 ++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: MEM-stage, device and data-memory buses
// around the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_rd;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              dev_req;
  logic              dev_we;
  logic [ADDR_W-1:0] dev_addr;
  logic [DATA_W-1:0] dev_wdata;
  logic              dev_ack;
  logic [DATA_W-1:0] dev_rdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  dev_req, dev_we, dev_addr, dev_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_stall,
    output dev_ack, dev_rdata,
    output mem_rd, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output dev_req, dev_we, dev_addr, dev_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_stall,
    input  dev_ack, dev_rdata,
    input  mem_rd, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU-first data-memory arbiter with one device port.
// DMEM_ARB_FAIRNESS_EN adds the starvation counter and forced slots.
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);
  typedef enum logic {ARB, DACK} state_t;

  state_t            state;
  logic              cpu_act;
  logic              dev_elig;
  logic              force_slot;
  logic              grant_cpu;
  logic              grant_dev;
  logic              sel_rd;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign cpu_act  = bus.cpu_rd | bus.cpu_wr;
  assign dev_elig = (state == ARB) && bus.dev_req;

`ifdef DMEM_ARB_FAIRNESS_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starve_cnt;
  assign force_slot = dev_elig && (starve_cnt == STARVE_LIM);
`else
  // Strict priority: the starvation bound is never reached.
  assign force_slot = (STARVE_MAX < 0);
`endif

  assign grant_cpu = cpu_act && !force_slot;
  assign grant_dev = force_slot || (dev_elig && !cpu_act);

  always_comb begin
    sel_addr  = bus.cpu_addr;
    sel_wdata = bus.cpu_wdata;
    sel_rd    = 1'b0;
    sel_wr    = 1'b0;
    unique case (1'b1)
      grant_dev: begin
        sel_addr  = bus.dev_addr;
        sel_wdata = bus.dev_wdata;
        sel_wr    = bus.dev_we;
        sel_rd    = ~bus.dev_we;
      end
      grant_cpu: begin
        sel_wr = bus.cpu_wr;
        sel_rd = bus.cpu_rd & ~bus.cpu_wr;
      end
      default: ;
    endcase
  end

  assign bus.mem_addr  = sel_addr;
  assign bus.mem_wdata = sel_wdata;
  assign bus.mem_rd    = sel_rd & ~reset;
  assign bus.mem_wr    = sel_wr & ~reset;
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.cpu_stall = force_slot & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ARB;
      bus.dev_ack   <= 1'b0;
      bus.dev_rdata <= '0;
`ifdef DMEM_ARB_FAIRNESS_EN
      starve_cnt    <= 4'd0;
`endif
    end else begin
      bus.dev_ack <= grant_dev;
      state       <= grant_dev ? DACK : ARB;
      if (grant_dev && !bus.dev_we)
        bus.dev_rdata <= bus.mem_rdata;
`ifdef DMEM_ARB_FAIRNESS_EN
      if (grant_dev || !bus.dev_req)
        starve_cnt <= 4'd0;
      else if (dev_elig && grant_cpu &&
               starve_cnt != STARVE_LIM)
        starve_cnt <= starve_cnt + 4'd1;
`endif
    end
  end
endmodule
